nuc_pattern_matcher: RTL and testbench
======================================

# nuc_pattern_matcher

Sequencer that sits directly downstream of the nucleotide and pattern memories. On `start`, it reads one 4‑nucleotide pattern word from pattern memory. It then streams the first `seq_len` nucleotides out of nucleotide memory and slides a 4‑nucleotide window over them. It counts every, possibly overlapping, window equal to the pattern and reports the start address of the first hit.

## Interface
Parameters:
- `NUC_AW`, 16, nucleotide memory address width (65536 entries × 2 bits)
- `PAT_AW`, 12, pattern memory address width (4096 entries × 8 bits)
- `CNT_W`, 16, match counter width

Ports:
- `clock`  in  1  sole clock; all state changes on posedge
- `reset_L`  in  1  synchronous, active-low reset, sampled on posedge `clock`
- `start`  in  1  begin a search; honoured only in IDLE
- `pat_sel`  in  PAT_AW  pattern memory address to search for
- `seq_len`  in  NUC_AW+1  number of nucleotides to scan, from address 0; values > 2^NUC_AW clamp to 2^NUC_AW
- `nuc_re`  out  1  nucleotide memory read enable
- `nuc_addr`  out  NUC_AW  nucleotide memory address
- `nuc_data`  in  2  nucleotide memory data; combinational read, valid in the same cycle
- `pat_re`  out  1  pattern memory read enable
- `pat_addr`  out  PAT_AW  pattern memory address
- `pat_data`  in  8  pattern memory data; combinational read, valid in the same cycle
- `busy`  out  1  high in LOADPAT and SCAN
- `done`  out  1  one-cycle pulse; results valid from this cycle on
- `match_count`  out  CNT_W  number of matching windows, saturating
- `found`  out  1  at least one match in the last search
- `first_addr`  out  NUC_AW  start address of the first match; 0 if `!found`

## Operation
- Encoding: A=00, C=01, G=10, T=11.
- Pattern bits [7:6] hold the first nucleotide and [1:0] the last.
- The block never writes either memory; the top ties memory `we` low.
- States:
  - IDLE: `busy`=0, `nuc_re`=`pat_re`=0. On `start`=1, latch `pat_sel` and the clamped `seq_len`, then go to LOADPAT. `start` outside IDLE is ignored.
  - LOADPAT (1 cycle): `pat_re`=1, `pat_addr`=latched `pat_sel`; register `pat_data` as the pattern. Clear window, `idx`, `match_count`, `found` and `first_addr`. Go to SCAN if length ≥ 4, else go to DONE.
  - SCAN: `nuc_re`=1, `nuc_addr`=`idx`.
    - `nextwin` = {window[5:0], `nuc_data`}; window <= `nextwin`; `idx` <= `idx`+1.
    - If `idx` ≥ 3 and `nextwin` == pattern: increment `match_count` (saturating at all-ones).
    - On the same condition, if `found`=0: set `found`=1 and `first_addr` <= `idx`−3.
    - When `idx` == length−1, go to DONE.
  - DONE (1 cycle): `done`=1, then go to IDLE.
- Results hold until the next accepted `start`.
- Reset values: state IDLE; `busy`, `done`, `nuc_re`, `pat_re`, `found`=0; `match_count`, `first_addr`, `nuc_addr`, `pat_addr`=0.
- Reset asserted mid-search: the search aborts and all outputs return to reset values on that edge.
- Internal `idx` is NUC_AW+1 bits wide so a full 65536-nucleotide scan terminates without wrap.

## Timing
- `start` sampled at edge E0. LOADPAT runs in cycle E0–E1. SCAN reads address k during cycle E(k+1)–E(k+2).
- `done` is high in the cycle after edge E(L+1), i.e. L+2 cycles after the start edge, for length L ≥ 4.
- For L < 4, `done` is high in the cycle after E1. `match_count`=0, `found`=0.
- `busy` falls in the same cycle `done` rises.
- A `start` in the `done` cycle is ignored; the block is back in IDLE the next cycle.
- Back-to-back searches: the next `start` is accepted one cycle after `done`.

## Test plan
- Nucs 0..7 = A C G T A C G T, pattern[5] = 8'b00011011 (ACGT), `pat_sel`=5, `seq_len`=8 -> `done` 10 cycles after start; `match_count`=2, `found`=1, `first_addr`=0.
- Nucs 0..5 = AAAAAA, pattern 8'h00, `seq_len`=6 -> overlapping matches give `match_count`=3, `first_addr`=0.
- Nucs 0..9 = CCCCCC then GGTT, pattern 8'b01101011 (CGGT? no: set to GGTT = 8'b10101111), `seq_len`=10 -> `match_count`=1, `first_addr`=6.
  - Also rerun with `seq_len`=9 -> `match_count`=0, `found`=0.
- `seq_len`=3 -> `done` 2 cycles after start, `match_count`=0, `nuc_re` never asserted.
- Reset mid-SCAN: `reset_L`=0 for 1 cycle at `idx`=4 -> next cycle all outputs 0 and state IDLE. A fresh `start` then completes normally.
- `CNT_W`=2, all-A memory, pattern 8'h00, `seq_len`=10 -> `match_count` saturates at 3; `start` pulsed during SCAN has no effect.

Source files
------------

// File: rtl/nuc_pattern_matcher.sv
// Slides a 4-nucleotide window over nucleotide memory and counts matches of one
// pattern word, reporting the start address of the first hit.
module nuc_pattern_matcher #(
    parameter int NUC_AW = 16,
    parameter int PAT_AW = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              start,
    input  logic [PAT_AW-1:0] pat_sel,
    input  logic [NUC_AW:0]   seq_len,
    output logic              nuc_re,
    output logic [NUC_AW-1:0] nuc_addr,
    input  logic [1:0]        nuc_data,
    output logic              pat_re,
    output logic [PAT_AW-1:0] pat_addr,
    input  logic [7:0]        pat_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_count,
    output logic              found,
    output logic [NUC_AW-1:0] first_addr
);

    localparam logic [NUC_AW:0] MAX_LEN = {1'b1, {NUC_AW{1'b0}}};

    typedef enum logic [1:0] {IDLE, LOADPAT, SCAN, DONE} state_t;

    state_t             state, next_state;
    logic [PAT_AW-1:0]  sel_q;
    logic [NUC_AW:0]    len_q;
    logic [7:0]         pattern;
    logic [7:0]         window;
    logic [NUC_AW:0]    idx;
    logic [NUC_AW:0]    idx_m3;
    logic [7:0]         nextwin;
    logic               hit;
    logic               last;

    assign nextwin = {window[5:0], nuc_data};
    assign hit     = (idx >= (NUC_AW+1)'(3)) && (nextwin == pattern);
    assign last    = (idx == len_q - (NUC_AW+1)'(1));
    assign idx_m3  = idx - (NUC_AW+1)'(3);

    always_ff @(posedge clock) begin
        if (!reset_L) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOADPAT;
            LOADPAT: next_state = (len_q >= (NUC_AW+1)'(4)) ? SCAN : DONE;
            SCAN:    if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == LOADPAT) || (state == SCAN);
        done     = (state == DONE);
        pat_re   = (state == LOADPAT);
        pat_addr = (state == LOADPAT) ? sel_q : '0;
        nuc_re   = (state == SCAN);
        nuc_addr = (state == SCAN) ? idx[NUC_AW-1:0] : '0;
    end

    // Request capture and scan datapath; validity is qualified by state.
    always_ff @(posedge clock) begin
        case (state)
            IDLE: if (start) begin
                sel_q <= pat_sel;
                len_q <= (seq_len > MAX_LEN) ? MAX_LEN : seq_len;
            end
            LOADPAT: begin
                pattern <= pat_data;
                window  <= '0;
                idx     <= '0;
            end
            SCAN: begin
                window <= nextwin;
                idx    <= idx + (NUC_AW+1)'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            match_count <= '0;
            found       <= 1'b0;
            first_addr  <= '0;
        end else if (state == LOADPAT) begin
            match_count <= '0;
            found       <= 1'b0;
            first_addr  <= '0;
        end else if (state == SCAN && hit) begin
            if (match_count != '1) match_count <= match_count + CNT_W'(1);
            if (!found) begin
                found      <= 1'b1;
                first_addr <= idx_m3[NUC_AW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_nuc_pattern_matcher.sv
// Scoreboard bench for nuc_pattern_matcher: a software window scan predicts each search.
module tb_nuc_pattern_matcher;

    logic        clock = 1'b0;
    logic        reset_L = 1'b0;
    logic        start = 1'b0, start2 = 1'b0;
    logic [11:0] pat_sel = '0, pat_sel2 = '0;
    logic [16:0] seq_len = '0, seq_len2 = '0;
    logic        nuc_re, nuc_re2, pat_re, pat_re2;
    logic [15:0] nuc_addr, nuc_addr2, first_addr, first_addr2;
    logic [11:0] pat_addr, pat_addr2;
    logic [1:0]  nuc_data, nuc_data2;
    logic [7:0]  pat_data, pat_data2;
    logic        busy, busy2, done, done2, found, found2;
    logic [15:0] match_count;
    logic [1:0]  match_count2;

    logic [1:0]  nuc_mem [0:65535];
    logic [7:0]  pat_mem [0:4095];

    assign nuc_data  = nuc_mem[nuc_addr];
    assign pat_data  = pat_mem[pat_addr];
    assign nuc_data2 = nuc_mem[nuc_addr2];
    assign pat_data2 = pat_mem[pat_addr2];

    always #5 clock = ~clock;

    nuc_pattern_matcher dut (
        .clock(clock), .reset_L(reset_L), .start(start), .pat_sel(pat_sel), .seq_len(seq_len),
        .nuc_re(nuc_re), .nuc_addr(nuc_addr), .nuc_data(nuc_data),
        .pat_re(pat_re), .pat_addr(pat_addr), .pat_data(pat_data),
        .busy(busy), .done(done), .match_count(match_count), .found(found), .first_addr(first_addr)
    );

    nuc_pattern_matcher #(.NUC_AW(16), .PAT_AW(12), .CNT_W(2)) dut2 (
        .clock(clock), .reset_L(reset_L), .start(start2), .pat_sel(pat_sel2), .seq_len(seq_len2),
        .nuc_re(nuc_re2), .nuc_addr(nuc_addr2), .nuc_data(nuc_data2),
        .pat_re(pat_re2), .pat_addr(pat_addr2), .pat_data(pat_data2),
        .busy(busy2), .done(done2), .match_count(match_count2), .found(found2), .first_addr(first_addr2)
    );

    typedef struct {
        int cnt;
        int fnd;
        int fa;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Independent reference: scan every 4-nucleotide window of the clamped length.
    function automatic exp_t model(input int len, input logic [7:0] pat, input int maxc);
        exp_t e;
        int   l;
        logic [7:0] w;
        l = (len > 65536) ? 65536 : len;
        e.cnt = 0; e.fnd = 0; e.fa = 0;
        for (int i = 0; i + 3 < l; i++) begin
            w = {nuc_mem[i], nuc_mem[i+1], nuc_mem[i+2], nuc_mem[i+3]};
            if (w == pat) begin
                if (e.cnt < maxc) e.cnt++;
                if (e.fnd == 0) begin
                    e.fnd = 1;
                    e.fa  = i;
                end
            end
        end
        e.lat = (l >= 4) ? l + 1 : 1;
        return e;
    endfunction

    task automatic search(input string tag, input logic [11:0] sel, input int len);
        exp_t e;
        int   cycles;
        bit   saw_re;
        exp_q.push_back(model(len, pat_mem[sel], 65535));
        @(negedge clock);
        start = 1'b1; pat_sel = sel; seq_len = 17'(len);
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_loadpat_re"}, {31'd0, pat_re}, 32'd1);
        check({tag, "_loadpat_addr"}, {20'd0, pat_addr}, {20'd0, sel});
        cycles = 1; saw_re = 1'b0;
        while (!done && cycles < len + 20) begin
            @(posedge clock); #1;
            if (nuc_re) saw_re = 1'b1;
            if (!done) cycles++;
        end
        e = exp_q.pop_front();
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_latency"}, cycles, e.lat);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_count"}, {16'd0, match_count}, e.cnt);
        check({tag, "_found"}, {31'd0, found}, e.fnd);
        check({tag, "_first_addr"}, {16'd0, first_addr}, e.fa);
        check({tag, "_nuc_re_used"}, {31'd0, saw_re}, (len >= 4) ? 32'd1 : 32'd0);
        // A start during the done cycle must be dropped.
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, "_start_in_done_ignored"}, {31'd0, busy}, 32'd0);
        check({tag, "_hold_count"}, {16'd0, match_count}, e.cnt);
    endtask

    initial begin
        int   cycles;
        exp_t e;
        for (int i = 0; i < 65536; i++) nuc_mem[i] = 2'b00;
        for (int i = 0; i < 4096; i++) pat_mem[i] = 8'hFF;

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_re", {30'd0, nuc_re, pat_re}, 32'd0);
        check("rst_results", {15'd0, found, match_count}, 32'd0);
        check("rst_addrs", {nuc_addr, first_addr}, 32'd0);
        check("rst_pat_addr", {20'd0, pat_addr}, 32'd0);
        reset_L = 1'b1;

        // ACGTACGT, pattern ACGT
        for (int i = 0; i < 8; i++) nuc_mem[i] = 2'(i % 4);
        pat_mem[5] = 8'b00011011;
        search("acgt", 12'd5, 8);

        // AAAAAA, pattern AAAA: overlapping hits
        for (int i = 0; i < 16; i++) nuc_mem[i] = 2'b00;
        pat_mem[9] = 8'h00;
        search("polyA", 12'd9, 6);

        // CCCCCCGGTT, pattern GGTT
        for (int i = 0; i < 6; i++) nuc_mem[i] = 2'b01;
        nuc_mem[6] = 2'b10; nuc_mem[7] = 2'b10; nuc_mem[8] = 2'b11; nuc_mem[9] = 2'b11;
        pat_mem[20] = 8'b10101111;
        search("ggtt10", 12'd20, 10);
        search("ggtt9", 12'd20, 9);

        search("short3", 12'd9, 3);
        search("zero", 12'd9, 0);

        // Reset in the middle of a scan
        for (int i = 0; i < 8; i++) nuc_mem[i] = 2'(i % 4);
        @(negedge clock);
        start = 1'b1; pat_sel = 12'd5; seq_len = 17'd8;
        @(posedge clock); #1;
        start = 1'b0;
        cycles = 0;
        while (!(nuc_re && nuc_addr == 16'd4) && cycles < 20) begin
            @(posedge clock); #1;
            cycles++;
        end
        check("midrst_reached_idx4", {31'd0, nuc_re}, 32'd1);
        @(negedge clock);
        reset_L = 1'b0;
        @(posedge clock); #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_re", {30'd0, nuc_re, pat_re}, 32'd0);
        check("midrst_count", {16'd0, match_count}, 32'd0);
        check("midrst_found", {31'd0, found}, 32'd0);
        check("midrst_addrs", {nuc_addr, first_addr}, 32'd0);
        reset_L = 1'b1;
        search("after_rst", 12'd5, 8);

        // Narrow counter: saturation, and a start during SCAN is ignored
        for (int i = 0; i < 16; i++) nuc_mem[i] = 2'b00;
        exp_q.push_back(model(10, pat_mem[9], 3));
        @(negedge clock);
        start2 = 1'b1; pat_sel2 = 12'd9; seq_len2 = 17'd10;
        @(posedge clock); #1;
        start2 = 1'b0;
        cycles = 1;
        while (!done2 && cycles < 40) begin
            start2 = (cycles == 4);
            pat_sel2 = (cycles == 4) ? 12'd5 : 12'd9;
            seq_len2 = (cycles == 4) ? 17'd4 : 17'd10;
            @(posedge clock); #1;
            if (!done2) cycles++;
        end
        start2 = 1'b0;
        e = exp_q.pop_front();
        check("sat_done_seen", {31'd0, done2}, 32'd1);
        check("sat_latency", cycles, e.lat);
        check("sat_count", {30'd0, match_count2}, e.cnt);
        check("sat_found", {31'd0, found2}, e.fnd);
        check("sat_first_addr", {16'd0, first_addr2}, e.fa);
        @(posedge clock); #1;
        check("sat_idle_after", {31'd0, busy2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
